// File: rtl/knight_rider_pkg.sv
// ----------------------------------------------------------------------------
// knight_rider_pkg
//   Shared types and constants for the Knight Rider LED scanner blocks.
//   - dir_state_t : direction FSM state. The encoding is chosen so that the
//                   state bit equals the dir output value.
//   - DIR_UP/DIR_DOWN : values driven on the dir line.
//   - DEFAULT_WIDTH   : default position counter width.
// ----------------------------------------------------------------------------
package knight_rider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        S_DOWN = 1'b0,
        S_UP   = 1'b1
    } dir_state_t;

endpackage : knight_rider_pkg

// File: rtl/fsm2_dir_ctrl.sv
// ----------------------------------------------------------------------------
// fsm2_dir_ctrl
//   Direction-control FSM for the LED scanner. Watches the external position
//   counter and flips the scan direction when the counter lands exactly on
//   the endpoint it is heading towards. Moore output, one state bit.
//
//   Parameters
//     WIDTH     : width of count
//     MAX_COUNT : top end of the scan (1 .. 2**WIDTH-1)
//   Ports
//     clk   in  : system clock, rising edge
//     reset in  : synchronous, active-high; forces S_UP
//     count in  : current scanner position
//     dir   out : 1 = counter increments (UP), 0 = decrements (DOWN)
// ----------------------------------------------------------------------------
module fsm2_dir_ctrl
    import knight_rider_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    output logic             dir
);

    // Endpoint must be representable in count and non-zero, otherwise the
    // two turn conditions would coincide or never fire.
    if (MAX_COUNT <= 0 || MAX_COUNT > 2**WIDTH - 1) begin : g_bad_max
        $error("fsm2_dir_ctrl: MAX_COUNT %0d out of range for WIDTH %0d",
               MAX_COUNT, WIDTH);
    end

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] BOT = '0;

    dir_state_t state_q, state_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_UP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: exact-equality endpoint compare only, so a counter that
    // wraps past an endpoint never causes a turn.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_UP:    if (count == TOP) state_d = S_DOWN;
            S_DOWN:  if (count == BOT) state_d = S_UP;
            default: state_d = S_UP;  // any corrupted encoding recovers to UP
        endcase
    end

    // Output decode from the state register only
    assign dir = (state_q == S_DOWN) ? DIR_DOWN : DIR_UP;

endmodule : fsm2_dir_ctrl

// File: tb/tb_fsm2_dir_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fsm2_dir_ctrl
//   Directed walk through the scanner scenarios followed by random count /
//   reset traffic, all checked against a behavioural model that tracks the
//   endpoint the scan is currently heading for.
// ----------------------------------------------------------------------------
module tb_fsm2_dir_ctrl;

    localparam int WIDTH = 4;
    localparam int MAXC  = 15;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] count;
    logic             dir;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: direction plus the endpoint that direction is heading for.
    bit exp_dir = 1'b1;

    fsm2_dir_ctrl #(.WIDTH(WIDTH), .MAX_COUNT(MAXC)) dut (
        .clk   (clk),
        .reset (reset),
        .count (count),
        .dir   (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: dir=%b expected=%b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply inputs, take one edge, advance the model, check just after.
    task automatic cyc(input int c, input bit r, input string tag);
        int target;
        count = c[WIDTH-1:0];
        reset = r;
        @(posedge clk);
        target = exp_dir ? MAXC : 0;   // endpoint the scan is moving toward
        if (r)
            exp_dir = 1'b1;
        else if (c == target)
            exp_dir = !exp_dir;
        #1;
        chk(tag, dir, exp_dir);
    endtask

    initial begin
        count = '0;
        reset = 1'b1;

        // Reset with count mid-range, then release at 0
        cyc(7, 1, "reset0");
        cyc(7, 1, "reset1");
        cyc(0, 0, "rel_at_0");

        // Upward sweep to the top endpoint
        for (int i = 1; i <= 15; i++) cyc(i, 0, "up_sweep");

        // Wrap 15 -> 0 while DOWN turns back up, then 0 -> 15 turns down
        cyc(0, 0, "wrap_up_turn");
        cyc(15, 0, "wrap_down_turn");

        // Downward sweep to 0
        for (int i = 14; i >= 0; i--) cyc(i, 0, "down_sweep");

        // Dwell on top while UP: exactly one turn
        for (int i = 0; i < 5; i++) cyc(15, 0, "dwell_top_up");
        // Dwell on top while DOWN: no change
        for (int i = 0; i < 3; i++) cyc(15, 0, "dwell_top_down");

        // Mid-scan reset from DOWN, then 0 must not turn
        cyc(9, 0, "pre_mid_rst");
        cyc(9, 1, "mid_rst");
        cyc(0, 0, "zero_after_rst");
        cyc(0, 0, "zero_hold_up");

        // Random traffic, biased toward endpoints, occasional reset
        for (int i = 0; i < 400; i++) begin
            int c;
            bit r;
            case ($urandom_range(0, 3))
                0:       c = 0;
                1:       c = MAXC;
                default: c = $urandom_range(0, MAXC);
            endcase
            r = ($urandom_range(0, 31) == 0);
            cyc(c, r, "random");
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule : tb_fsm2_dir_ctrl
